seven_seg_decoder: RTL and testbench

- Registered hex-digit to 7-segment decoder for the board HEX displays.
- Each instance takes one 4-bit nibble, for example a slice of a debug value such as a bounding-box coordinate.
- Each instance drives one display digit through a single output register.
- Four instances cover a 16-bit value on HEX3..HEX0.

---
 rtl/seven_seg_decoder.sv | 100 ++++++++++
 tb/tb_seven_seg_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//
// Registered hex-digit to 7-segment decoder for one board HEX display digit.
// A 4-bit nibble is decoded to segment drive and loaded into a single output
// register, so OUT always shows the IN/BLANK value sampled at the previous
// rising edge of I_CLK. Four instances cover a 16-bit value on HEX3..HEX0.
//
// Parameters:
//   ACTIVE_LOW  1: a lit segment is driven 0 (board HEX pins).
//               0: a lit segment is driven 1.
//
// Ports:
//   I_CLK      in   1  system clock, rising edge
//   I_RST      in   1  synchronous active-high reset; loads the blank pattern
//   IN         in   4  hex digit to display, 0x0-0xF
//   BLANK      in   1  1 turns all segments off
//   LAMP_TEST  in   1  1 lights all segments (only with SEVENSEG_LAMP_TEST_EN)
//   OUT        out  7  registered segment drive, OUT[0]=a ... OUT[6]=g
//
// Build option:
//   SEVENSEG_LAMP_TEST_EN  adds the LAMP_TEST input, which overrides BLANK
//                          and IN (reset still has the highest priority).
// -----------------------------------------------------------------------------
module seven_seg_decoder #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic [3:0] IN,
    input  logic       BLANK,
`ifdef SEVENSEG_LAMP_TEST_EN
    input  logic       LAMP_TEST,
`endif
    output logic [6:0] OUT
);

    // Pin-level patterns for "all off" and "all on" in the selected polarity.
    localparam logic [6:0] PAT_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] PAT_ALL   = ACTIVE_LOW ? 7'h00 : 7'h7F;

    logic [6:0] w_lit;    // segments to light, 1 = lit, bit order g..a
    logic [6:0] w_drive;  // w_lit converted to pin polarity
    logic [6:0] w_next;   // next value of the output register
    logic       w_lamp;
    logic [6:0] r_out;

`ifdef SEVENSEG_LAMP_TEST_EN
    assign w_lamp = LAMP_TEST;
`else
    assign w_lamp = 1'b0;
`endif

    // Glyphs use lower-case b and d so they stay distinct from 8 and 0.
    always_comb begin
        w_lit = 7'h00;
        unique case (IN)
            4'h0: w_lit = 7'h3F;
            4'h1: w_lit = 7'h06;
            4'h2: w_lit = 7'h5B;
            4'h3: w_lit = 7'h4F;
            4'h4: w_lit = 7'h66;
            4'h5: w_lit = 7'h6D;
            4'h6: w_lit = 7'h7D;
            4'h7: w_lit = 7'h07;
            4'h8: w_lit = 7'h7F;
            4'h9: w_lit = 7'h6F;
            4'hA: w_lit = 7'h77;
            4'hB: w_lit = 7'h7C;
            4'hC: w_lit = 7'h39;
            4'hD: w_lit = 7'h5E;
            4'hE: w_lit = 7'h79;
            4'hF: w_lit = 7'h71;
            default: w_lit = 7'h00;
        endcase
    end

    assign w_drive = ACTIVE_LOW ? ~w_lit : w_lit;

    // Reset is handled in the register; remaining priority is lamp, blank, decode.
    always_comb begin
        w_next = w_drive;
        if (w_lamp) begin
            w_next = PAT_ALL;
        end else if (BLANK) begin
            w_next = PAT_BLANK;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_out <= PAT_BLANK;
        end else begin
            r_out <= w_next;
        end
    end

    assign OUT = r_out;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_decoder
//
// Drives one ACTIVE_LOW=1 and one ACTIVE_LOW=0 instance from the same inputs
// and compares both outputs after every edge against a reference model that
// builds each glyph from the list of segment letters it lights.
// -----------------------------------------------------------------------------
module tb_seven_seg_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       blank;
    logic       lamp;
    logic [6:0] out_lo;
    logic [6:0] out_hi;

    int n_pass  = 0;
    int n_total = 0;

    // Segment letters lit for each hex digit (b and d are lower-case glyphs).
    string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                          "abc", "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg",
                          "adefg", "aefg"};

    seven_seg_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .I_CLK     (clk),
        .I_RST     (rst),
        .IN        (din),
        .BLANK     (blank),
`ifdef SEVENSEG_LAMP_TEST_EN
        .LAMP_TEST (lamp),
`endif
        .OUT       (out_lo)
    );

    seven_seg_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .I_CLK     (clk),
        .I_RST     (rst),
        .IN        (din),
        .BLANK     (blank),
`ifdef SEVENSEG_LAMP_TEST_EN
        .LAMP_TEST (lamp),
`endif
        .OUT       (out_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set of lit segments (1 = lit, bit 0 = a) from the glyph letter list.
    function automatic logic [6:0] lit_set(input logic [3:0] d);
        string      s;
        logic [6:0] m;
        s = glyph[d];
        m = 7'h00;
        for (int i = 0; i < s.len(); i++) begin
            m[int'(s[i]) - 97] = 1'b1;
        end
        return m;
    endfunction

    // Expected pin drive for an active-high-lit display (ACTIVE_LOW=0).
    function automatic logic [6:0] model_hi(input logic r, input logic l, input logic b,
                                            input logic [3:0] d);
        if (r) return 7'h00;
        if (l) return 7'h7F;
        if (b) return 7'h00;
        return lit_set(d);
    endfunction

    // Inputs are applied, then the edge, then outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 4'h8; blank = 1'b0; lamp = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if (out_lo !== 7'h7F)
                $display("FAIL reset_lo cycle %0d: got %h want 7f", c, out_lo);
            else n_pass++;
            n_total++;
            if (out_hi !== 7'h00)
                $display("FAIL reset_hi cycle %0d: got %h want 00", c, out_hi);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
        n_total++;
        if (out_lo !== 7'h00) $display("FAIL reset_release_lo: got %h want 00", out_lo);
        else n_pass++;
        n_total++;
        if (out_hi !== 7'h7F) $display("FAIL reset_release_hi: got %h want 7f", out_hi);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [6:0] exp;
        rst = 1'b0; blank = 1'b0; lamp = 1'b0;
        for (int d = 0; d < 16; d++) begin
            din = 4'(d);
            tick();
            exp = model_hi(1'b0, 1'b0, 1'b0, din);
            n_total++;
            if (out_lo !== ~exp) $display("FAIL sweep_lo in=%h: got %h want %h", din, out_lo, ~exp);
            else n_pass++;
            n_total++;
            if (out_hi !== exp) $display("FAIL sweep_hi in=%h: got %h want %h", din, out_hi, exp);
            else n_pass++;
        end
        // Spot values straight from the published table.
        din = 4'hA;
        tick();
        n_total++;
        if (out_lo !== 7'h08) $display("FAIL sweep_table_A: got %h want 08", out_lo);
        else n_pass++;
    endtask

    task automatic test_blank();
        rst = 1'b0; lamp = 1'b0; din = 4'h3; blank = 1'b1;
        tick();
        n_total++;
        if (out_lo !== 7'h7F) $display("FAIL blank_on: got %h want 7f", out_lo);
        else n_pass++;
        n_total++;
        if (out_hi !== 7'h00) $display("FAIL blank_on_hi: got %h want 00", out_hi);
        else n_pass++;
        blank = 1'b0;
        tick();
        n_total++;
        if (out_lo !== 7'h30) $display("FAIL blank_off: got %h want 30", out_lo);
        else n_pass++;
    endtask

    task automatic test_midstream_reset();
        logic [6:0] exp;
        logic [3:0] seq [6] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
        blank = 1'b0; lamp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            din = seq[c];
            rst = (c == 3);
            tick();
            exp = model_hi(rst, 1'b0, 1'b0, din);
            n_total++;
            if (out_lo !== ~exp) $display("FAIL midrst_lo c=%0d: got %h want %h", c, out_lo, ~exp);
            else n_pass++;
            n_total++;
            if (out_hi !== exp) $display("FAIL midrst_hi c=%0d: got %h want %h", c, out_hi, exp);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

`ifdef SEVENSEG_LAMP_TEST_EN
    task automatic test_lamp();
        rst = 1'b0; lamp = 1'b1; blank = 1'b1; din = 4'h5;
        tick();
        n_total++;
        if (out_lo !== 7'h00) $display("FAIL lamp_on: got %h want 00", out_lo);
        else n_pass++;
        n_total++;
        if (out_hi !== 7'h7F) $display("FAIL lamp_on_hi: got %h want 7f", out_hi);
        else n_pass++;
        lamp = 1'b0;
        tick();
        n_total++;
        if (out_lo !== 7'h7F) $display("FAIL lamp_off_blank: got %h want 7f", out_lo);
        else n_pass++;
        rst = 1'b1; lamp = 1'b1;
        tick();
        n_total++;
        if (out_lo !== 7'h7F) $display("FAIL lamp_under_reset: got %h want 7f", out_lo);
        else n_pass++;
        rst = 1'b0; lamp = 1'b0; blank = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [6:0] exp;
        for (int c = 0; c < 300; c++) begin
            din   = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 19) == 0);
`ifdef SEVENSEG_LAMP_TEST_EN
            lamp  = ($urandom_range(0, 5) == 0);
`else
            lamp  = 1'b0;
`endif
            tick();
            exp = model_hi(rst, lamp, blank, din);
            n_total++;
            if (out_lo !== ~exp)
                $display("FAIL random_lo c=%0d in=%h b=%0d r=%0d: got %h want %h",
                         c, din, blank, rst, out_lo, ~exp);
            else n_pass++;
            n_total++;
            if (out_hi !== exp)
                $display("FAIL random_hi c=%0d in=%h b=%0d r=%0d: got %h want %h",
                         c, din, blank, rst, out_hi, exp);
            else n_pass++;
        end
        rst = 1'b0; blank = 1'b0; lamp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 4'h0; blank = 1'b0; lamp = 1'b0;
        test_reset();
        test_sweep();
        test_blank();
        test_midstream_reset();
`ifdef SEVENSEG_LAMP_TEST_EN
        test_lamp();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
